// File: rtl/circuit1_hlsm_ctrl_pkg.sv
// rtl/circuit1_hlsm_ctrl_pkg.sv - shared state encodings, ALU opcodes and state decode helper
package circuit1_hlsm_ctrl_pkg;

    localparam int DATAWIDTH_DEF = 8;

    // 3-bit state encodings; values 6 and 7 are illegal and decode to S_WAIT
    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S1      = 3'd1;
    localparam logic [2:0] S2      = 3'd2;
    localparam logic [2:0] S3      = 3'd3;
    localparam logic [2:0] S4      = 3'd4;
    localparam logic [2:0] S_FINAL = 3'd5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_GT  = 2'd2
    } alu_op_e;

    // Map any illegal encoding onto S_WAIT so the FSM always recovers to idle
    function automatic logic [2:0] decode_state(input logic [2:0] s);
        case (s)
            S_WAIT, S1, S2, S3, S4, S_FINAL: decode_state = s;
            default:                         decode_state = S_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/circuit1_hlsm_ctrl_if.sv
// rtl/circuit1_hlsm_ctrl_if.sv - start/done handshake, operand and result bundle
interface circuit1_hlsm_ctrl_if #(
    parameter int DATAWIDTH = 8
) ();

    logic                           start;
    logic signed [DATAWIDTH-1:0]    a;
    logic signed [DATAWIDTH-1:0]    b;
    logic signed [DATAWIDTH-1:0]    c;
    logic                           busy;
    logic                           done;
    logic signed [DATAWIDTH-1:0]    z;
    logic signed [2*DATAWIDTH-1:0]  x;

    // The surrounding system requests runs and reads results
    modport master (
        output start, a, b, c,
        input  busy, done, z, x
    );

    // The controller accepts runs and publishes results
    modport slave (
        input  start, a, b, c,
        output busy, done, z, x
    );

endinterface

// File: rtl/circuit1_hlsm_ctrl_alu.sv
// rtl/circuit1_hlsm_ctrl_alu.sv - shared add/sub/signed-compare ALU
module hlsm_alu
    import circuit1_hlsm_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_op_e                 op_i,
    input  logic signed [WIDTH-1:0] in0_i,
    input  logic signed [WIDTH-1:0] in1_i,
    output logic signed [WIDTH-1:0] result_o,
    output logic                    gt_o
);

    // Single combinational unit; gt is always available, result depends on op
    always_comb begin
        gt_o     = (in0_i > in1_i);
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = in0_i + in1_i;
            ALU_SUB: result_o = in0_i - in1_i;
            ALU_GT:  result_o = {{(WIDTH-1){1'b0}}, gt_o};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/circuit1_hlsm_ctrl.sv
// rtl/circuit1_hlsm_ctrl.sv - 5-cycle resource-shared circuit1 controller and datapath
module circuit1_hlsm_ctrl
    import circuit1_hlsm_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    circuit1_hlsm_ctrl_if.slave  bus
);

    localparam int DW = DATAWIDTH;
    localparam int W2 = 2 * DATAWIDTH;

    logic [2:0]              state_q, state_d, state_cur;
    logic signed [DW-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic signed [DW-1:0]    d_q, d_d, e_q, e_d;
    logic signed [W2-1:0]    f_q, f_d, xr_q, xr_d;
    logic                    g_q, g_d;
    logic signed [DW-1:0]    z_q, z_d;
    logic signed [W2-1:0]    x_q, x_d;

    alu_op_e                 alu_op;
    logic signed [W2-1:0]    alu_in0, alu_in1, alu_res;
    logic                    alu_gt;
    logic signed [W2-1:0]    mul_res;

    assign state_cur = decode_state(state_q);

    // Full-width signed product; operands are extended to W2 before multiplying
    assign mul_res = ra_q * rc_q;

    hlsm_alu #(.WIDTH(W2)) u_alu (
        .op_i     (alu_op),
        .in0_i    (alu_in0),
        .in1_i    (alu_in1),
        .result_o (alu_res),
        .gt_o     (alu_gt)
    );

    // ALU opcode and sign-extended operand selection per state
    always_comb begin
        alu_op  = ALU_ADD;
        alu_in0 = '0;
        alu_in1 = '0;
        case (state_cur)
            S1: begin
                alu_op  = ALU_ADD;
                alu_in0 = {{DW{ra_q[DW-1]}}, ra_q};
                alu_in1 = {{DW{rb_q[DW-1]}}, rb_q};
            end
            S2: begin
                alu_op  = ALU_ADD;
                alu_in0 = {{DW{ra_q[DW-1]}}, ra_q};
                alu_in1 = {{DW{rc_q[DW-1]}}, rc_q};
            end
            S3: begin
                alu_op  = ALU_SUB;
                alu_in0 = f_q;
                alu_in1 = {{DW{d_q[DW-1]}}, d_q};
            end
            S4: begin
                alu_op  = ALU_GT;
                alu_in0 = {{DW{d_q[DW-1]}}, d_q};
                alu_in1 = {{DW{e_q[DW-1]}}, e_q};
            end
            default: begin
                alu_op  = ALU_ADD;
                alu_in0 = '0;
                alu_in1 = '0;
            end
        endcase
    end

    // Next-state and register-update logic; d/e keep only the low DW bits (wrap)
    always_comb begin
        state_d = state_cur;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        xr_d    = xr_q;
        g_d     = g_q;
        z_d     = z_q;
        x_d     = x_q;
        case (state_cur)
            S_WAIT: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    rc_d    = bus.c;
                    state_d = S1;
                end
            end
            S1: begin
                d_d     = alu_res[DW-1:0];
                f_d     = mul_res;
                state_d = S2;
            end
            S2: begin
                e_d     = alu_res[DW-1:0];
                state_d = S3;
            end
            S3: begin
                xr_d    = alu_res;
                state_d = S4;
            end
            S4: begin
                g_d     = alu_gt;
                state_d = S_FINAL;
            end
            S_FINAL: begin
                // d==e leaves g clear, so e is selected on a tie
                z_d     = g_q ? d_q : e_q;
                x_d     = xr_q;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_WAIT;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            xr_q    <= '0;
            g_q     <= 1'b0;
            z_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            xr_q    <= xr_d;
            g_q     <= g_d;
            z_q     <= z_d;
            x_q     <= x_d;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        bus.busy = (state_cur == S1) || (state_cur == S2) ||
                   (state_cur == S3) || (state_cur == S4);
        bus.done = (state_cur == S_FINAL);
        bus.z    = z_q;
        bus.x    = x_q;
    end

endmodule

// File: tb/tb_circuit1_hlsm_ctrl.sv
// tb/tb_circuit1_hlsm_ctrl.sv - directed self-checking bench for circuit1_hlsm_ctrl
module tb_circuit1_hlsm_ctrl;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   done_cnt;
    int   done_ref;

    circuit1_hlsm_ctrl_if #(.DATAWIDTH(8)) bus ();

    circuit1_hlsm_ctrl #(.DATAWIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulse start with the given operands and follow the run to visible results
    task automatic run(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ic, input logic [7:0] ez, input logic [15:0] ex);
        bus.a = ia;
        bus.b = ib;
        bus.c = ic;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            chk({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
            if (cyc == 4) chk({tag, "_nodone4"}, {15'd0, bus.done}, 16'd0);
            else tick();
        end
        tick();
        chk({tag, "_done5"}, {15'd0, bus.done}, 16'd1);
        chk({tag, "_idle5"}, {15'd0, bus.busy}, 16'd0);
        tick();
        chk({tag, "_done6"}, {15'd0, bus.done}, 16'd0);
        chk({tag, "_z"}, {8'h00, bus.z}, {8'h00, ez});
        chk({tag, "_x"}, bus.x, ex);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c     = '0;
        tick();
        tick();
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        chk("rst_z", {8'h00, bus.z}, 16'h0000);
        chk("rst_x", bus.x, 16'h0000);
        rst = 1'b0;
        tick();

        run("c1", 8'd3, 8'd4, 8'd2, 8'h07, 16'hFFFF);
        run("c2", 8'hFE, 8'd1, 8'd5, 8'h03, 16'hFFF7);
        run("c3", 8'd100, 8'd100, 8'h80, 8'hE4, 16'hCE38);

        // Start held/re-pulsed mid-run with operands changing after capture
        done_ref = done_cnt;
        bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd2;
        bus.start = 1'b1;
        tick();                                  // cycle 1
        bus.start = 1'b0;
        bus.a = 8'd10; bus.b = 8'd10; bus.c = 8'd10;
        tick();                                  // cycle 2
        bus.start = 1'b1;
        tick();                                  // cycle 3
        tick();                                  // cycle 4
        chk("c4_busy4", {15'd0, bus.busy}, 16'd1);
        tick();                                  // cycle 5
        chk("c4_done5", {15'd0, bus.done}, 16'd1);
        tick();                                  // cycle 6: accepted again
        chk("c4_z", {8'h00, bus.z}, 16'h0007);
        chk("c4_x", bus.x, 16'hFFFF);
        chk("c4_cnt1", 16'(done_cnt - done_ref), 16'd1);
        tick();                                  // cycle 7 = run 2 S1
        bus.start = 1'b0;
        bus.a = 8'd1; bus.b = 8'd1; bus.c = 8'd1;
        chk("c4_rerun_busy", {15'd0, bus.busy}, 16'd1);
        for (int i = 0; i < 5; i++) tick();      // run 2 cycle 6
        chk("c4_r2_z", {8'h00, bus.z}, 16'h0014);
        chk("c4_r2_x", bus.x, 16'h0050);
        for (int i = 0; i < 4; i++) tick();
        chk("c4_cnt2", 16'(done_cnt - done_ref), 16'd2);

        // Reset asserted during S3 aborts the run without a done pulse
        done_ref = done_cnt;
        bus.a = 8'hFE; bus.b = 8'd1; bus.c = 8'd5;
        bus.start = 1'b1;
        tick();                                  // S1
        bus.start = 1'b0;
        tick();                                  // S2
        tick();                                  // S3
        chk("c5_inS3", {15'd0, bus.busy}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c5_busy", {15'd0, bus.busy}, 16'd0);
        chk("c5_done", {15'd0, bus.done}, 16'd0);
        chk("c5_z", {8'h00, bus.z}, 16'h0000);
        chk("c5_x", bus.x, 16'h0000);
        for (int i = 0; i < 6; i++) tick();
        chk("c5_nodone", 16'(done_cnt - done_ref), 16'd0);
        run("c5r", 8'd3, 8'd4, 8'd2, 8'h07, 16'hFFFF);

        // Tie d==e selects e; results hold while idle
        run("c6", 8'd5, 8'd7, 8'd7, 8'h0C, 16'h0017);
        done_ref = done_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("c6_hold_z", {8'h00, bus.z}, 16'h000C);
            chk("c6_hold_x", bus.x, 16'h0017);
        end
        chk("c6_nodone", 16'(done_cnt - done_ref), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
